// File: rtl/comparador_serial_der_izq_if.sv
// Operand/result bundle for the bit-serial comparator; the requester drives the master side.
// Relation codes on (y,z): EQ=01, GT=10, LT=11, 00 = no result.
interface comparador_serial_der_izq_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic         y;
  logic         z;
  logic         valid;

  modport master (
    output start, A, B,
    input  busy, done, y, z, valid
  );

  modport slave (
    input  start, A, B,
    output busy, done, y, z, valid
  );
endinterface

// File: rtl/comparador_serial_der_izq.sv
// LSB-first bit-serial magnitude comparator: one bit per clock, done N edges after start acceptance.
// No backpressure: start is taken only while not busy (IDLE or DONE), ignored during the scan.
module comparador_serial_der_izq #(
  parameter int N = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  comparador_serial_der_izq_if.slave   bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] REL_NONE = 2'b00;
  localparam logic [1:0] REL_EQ   = 2'b01;
  localparam logic [1:0] REL_GT   = 2'b10;
  localparam logic [1:0] REL_LT   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [1:0]    rel_q, rel_d;
  logic          valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rel_q   <= REL_NONE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rel_q   <= rel_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rel_d   = rel_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_SHIFT;
          a_d     = bus.A;
          b_d     = bus.B;
          cnt_d   = '0;
          rel_d   = REL_EQ;
          valid_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        // Later (more significant) bits overwrite whatever the lower bits decided.
        if (a_q[0] && !b_q[0]) begin
          rel_d = REL_GT;
        end else if (!a_q[0] && b_q[0]) begin
          rel_d = REL_LT;
        end
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy  = (state_q == S_SHIFT);
  assign bus.done  = (state_q == S_DONE);
  assign bus.valid = valid_q;
  assign bus.y     = rel_q[1];
  assign bus.z     = rel_q[0];

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Directed bench for the LSB-first serial comparator: per-edge scan trace, done timing, ignored start,
// back-to-back start in DONE, and asynchronous reset mid-scan.
module tb_comparador_serial_der_izq;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  comparador_serial_der_izq_if #(.N(N)) bus ();

  comparador_serial_der_izq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
  endtask

  // tr holds the expected relation after each processed bit: tr[1:0] after bit 0 ... tr[7:6] final.
  task automatic do_cmp(input string tag, input logic [7:0] tr, input bit noise);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = ~bus.A;
    bus.B     = ~bus.B;
    chk({tag, "/acc_busy"},  {7'd0, bus.busy},  8'd1);
    chk({tag, "/acc_valid"}, {7'd0, bus.valid}, 8'd0);
    chk({tag, "/acc_done"},  {7'd0, bus.done},  8'd0);
    chk({tag, "/acc_rel"},   {6'd0, bus.y, bus.z}, 8'b01);
    for (int i = 1; i < N; i++) begin
      @(posedge clk); #1;
      if (noise && i == 2) bus.start = 1'b0;
      chk({tag, "/scan_busy"}, {7'd0, bus.busy}, 8'd1);
      chk({tag, "/scan_done"}, {7'd0, bus.done}, 8'd0);
      chk({tag, "/scan_rel"},  {6'd0, bus.y, bus.z}, {6'd0, tr[2*(i-1) +: 2]});
      if (noise && i == 1) begin
        bus.start = 1'b1;
        bus.A     = 4'b0000;
        bus.B     = 4'b1111;
      end
    end
    @(posedge clk); #1;
    chk({tag, "/fin_done"},  {7'd0, bus.done},  8'd1);
    chk({tag, "/fin_busy"},  {7'd0, bus.busy},  8'd0);
    chk({tag, "/fin_valid"}, {7'd0, bus.valid}, 8'd1);
    chk({tag, "/fin_rel"},   {6'd0, bus.y, bus.z}, {6'd0, tr[7:6]});
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    #2;
    chk("rst_busy",  {7'd0, bus.busy},  8'd0);
    chk("rst_done",  {7'd0, bus.done},  8'd0);
    chk("rst_valid", {7'd0, bus.valid}, 8'd0);
    chk("rst_rel",   {6'd0, bus.y, bus.z}, 8'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // 0101 vs 0011: EQ, LT, GT, GT -> GT
    @(negedge clk); launch(4'b0101, 4'b0011);
    do_cmp("t1", 8'b10_10_11_01, 1'b0);
    @(posedge clk); #1;
    chk("t1_idle_done",  {7'd0, bus.done},  8'd0);
    chk("t1_idle_busy",  {7'd0, bus.busy},  8'd0);
    chk("t1_idle_valid", {7'd0, bus.valid}, 8'd1);
    chk("t1_idle_rel",   {6'd0, bus.y, bus.z}, 8'b10);

    // 0011 vs 1100: GT, GT, LT, LT -> LT
    @(negedge clk); launch(4'b0011, 4'b1100);
    do_cmp("t2", 8'b11_11_10_10, 1'b0);

    // equal operands stay EQ
    @(negedge clk); launch(4'b1001, 4'b1001);
    do_cmp("t3", 8'b01_01_01_01, 1'b0);

    // MSB overrides lower bits: LT, LT, LT, GT
    @(negedge clk); launch(4'b1000, 4'b0111);
    do_cmp("t4", 8'b10_11_11_11, 1'b0);

    // 1100 vs 0110 with a stray start mid-scan: EQ, LT, LT, GT
    @(negedge clk); launch(4'b1100, 4'b0110);
    do_cmp("t5", 8'b10_11_11_01, 1'b1);
    // start in the DONE cycle: 0010 vs 0100 -> EQ, GT, LT, LT
    launch(4'b0010, 4'b0100);
    do_cmp("t6", 8'b11_11_10_01, 1'b0);

    // asynchronous reset in the middle of the 3rd SHIFT cycle
    @(negedge clk); launch(4'b1111, 4'b0000);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("t7_busy",  {7'd0, bus.busy},  8'd0);
    chk("t7_done",  {7'd0, bus.done},  8'd0);
    chk("t7_valid", {7'd0, bus.valid}, 8'd0);
    chk("t7_rel",   {6'd0, bus.y, bus.z}, 8'b00);
    repeat (2) begin
      @(posedge clk); #1;
      chk("t7_hold_done", {7'd0, bus.done}, 8'd0);
      chk("t7_hold_busy", {7'd0, bus.busy}, 8'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // 0111 vs 0110: GT from bit 0 onwards
    @(negedge clk); launch(4'b0111, 4'b0110);
    do_cmp("t8", 8'b10_10_10_10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
